// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its edge-detect front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package period_meter_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Measurement FSM encoding: IDLE=0, ARM=1, MEAS=2.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  // All-ones value for a counter of width w (saturation / timeout threshold).
  function automatic logic [31:0] cnt_max(input int w);
    cnt_max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous 1-bit level and flags its rising edges.
// Latency: s_o follows SIG_i after SYNC_STAGES edges; rise_o is combinational from s_o and one history flop.
// Backpressure: none, free-running every cycle.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_i,
  input  logic RSTN_i,
  input  logic SIG_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures rising-edge-to-rising-edge period (and high time when PERIOD_METER_DUTY_EN is defined) of a slow async signal.
// Latency: VALID_o rises SYNC_STAGES+1 cycles after the edge is first sampled; TIMEOUT_o when the counter saturates.
// Backpressure: none; VALID_o/TIMEOUT_o are one-cycle strobes, results hold until the next measurement.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             SIG_i,
  input  logic             EN_i,
  output logic [CNT_W-1:0] PERIOD_o,
  output logic [CNT_W-1:0] HIGH_o,
  output logic             VALID_o,
  output logic             TIMEOUT_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             sig_s;
  logic             sig_rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d;
  logic             timeout_d;
`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_d;
`else
  logic             unused_sig_s;
  assign unused_sig_s = sig_s;
`endif

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK_i  (CLK_i),
    .RSTN_i (RSTN_i),
    .SIG_i  (SIG_i),
    .s_o    (sig_s),
    .rise_o (sig_rise)
  );

  // FSM state register.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, counter updates and strobes; a rise on the saturating cycle still reports a period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = PERIOD_o;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef PERIOD_METER_DUTY_EN
    hcnt_d    = hcnt_q;
    high_d    = HIGH_o;
`endif
    if (!EN_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef PERIOD_METER_DUTY_EN
      hcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end
        ST_ARM: begin
          // First edge only opens the window; the partial cycle before it is never reported.
          if (sig_rise) begin
            state_d = ST_MEAS;
            cnt_d   = CNT_W'(1);
`ifdef PERIOD_METER_DUTY_EN
            hcnt_d  = CNT_W'(1);
`endif
          end
        end
        ST_MEAS: begin
          if (sig_rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_W'(1);
`ifdef PERIOD_METER_DUTY_EN
            high_d   = hcnt_q;
            hcnt_d   = CNT_W'(1);
`endif
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
            cnt_d     = '0;
`ifdef PERIOD_METER_DUTY_EN
            hcnt_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef PERIOD_METER_DUTY_EN
            if (sig_s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
`ifdef PERIOD_METER_DUTY_EN
          hcnt_d  = '0;
`endif
        end
      endcase
    end
  end

  // Counters and registered result/strobe outputs.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      cnt_q     <= '0;
      PERIOD_o  <= '0;
      VALID_o   <= 1'b0;
      TIMEOUT_o <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
      hcnt_q    <= '0;
      HIGH_o    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      PERIOD_o  <= period_d;
      VALID_o   <= valid_d;
      TIMEOUT_o <= timeout_d;
`ifdef PERIOD_METER_DUTY_EN
      hcnt_q    <= hcnt_d;
      HIGH_o    <= high_d;
`endif
    end
  end

`ifndef PERIOD_METER_DUTY_EN
  assign HIGH_o = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: table of square waves on a 16-bit instance, corner sequences on a 4-bit instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_period_meter;
  import period_meter_pkg::*;

`ifdef PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig   = 1'b0;
  logic        en    = 1'b0;
  logic        sig4  = 1'b0;
  logic        en4   = 1'b0;
  logic [15:0] period, high;
  logic        valid, timeout;
  logic [3:0]  period4, high4;
  logic        valid4, timeout4;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int timeout_cnt = 0;
  logic [15:0] exp_period = '0;
  logic [15:0] exp_high   = '0;

  typedef struct {
    int          per;
    int          hi;
    logic [15:0] exp_period;
    logic [15:0] exp_high;
  } vec_t;

  vec_t tbl[6];

  period_meter u_dut (
    .CLK_i(clk), .RSTN_i(rst_n), .SIG_i(sig), .EN_i(en),
    .PERIOD_o(period), .HIGH_o(high), .VALID_o(valid), .TIMEOUT_o(timeout)
  );

  period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .CLK_i(clk), .RSTN_i(rst_n), .SIG_i(sig4), .EN_i(en4),
    .PERIOD_o(period4), .HIGH_o(high4), .VALID_o(valid4), .TIMEOUT_o(timeout4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < p; i++) begin
        sig = (i < h);
        tick();
      end
    end
    sig = 1'b0;
  endtask

  task automatic restart();
    en  = 1'b0;
    sig = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (2) tick();
  endtask

  // Every strobe from the wide instance is checked against the current expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid === 1'b1) begin
        valid_cnt++;
        chk("valid_period", 32'(period), 32'(exp_period));
        chk("valid_high", 32'(high), 32'(exp_high));
      end
      if (timeout === 1'b1) timeout_cnt++;
    end
  end

  initial begin
    int v0, v1, tmo;

    tbl[0] = '{2,  1, 16'd2,  DUTY ? 16'd1 : 16'd0};
    tbl[1] = '{10, 3, 16'd10, DUTY ? 16'd3 : 16'd0};
    tbl[2] = '{10, 5, 16'd10, DUTY ? 16'd5 : 16'd0};
    tbl[3] = '{7,  6, 16'd7,  DUTY ? 16'd6 : 16'd0};
    tbl[4] = '{4,  1, 16'd4,  DUTY ? 16'd1 : 16'd0};
    tbl[5] = '{16, 8, 16'd16, DUTY ? 16'd8 : 16'd0};

    // Reset state.
    repeat (2) tick();
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_period4", 32'(period4), 0);
    chk("rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Table: four rises per vector give three reports of the same period/high.
    for (int v = 0; v < 6; v++) begin
      exp_period = tbl[v].exp_period;
      exp_high   = tbl[v].exp_high;
      restart();
      v0 = valid_cnt;
      wave(tbl[v].per, tbl[v].hi, 4);
      repeat (6) tick();
      chk("vec_valid_count", 32'(valid_cnt - v0), 3);
    end

    // Strobe latency and width after a synchronously driven rise.
    exp_period = 16'd5;
    exp_high   = DUTY ? 16'd1 : 16'd0;
    restart();
    wave(5, 1, 1);
    sig = 1'b1;
    tick();
    chk("lat_e1", 32'(valid), 0);
    sig = 1'b0;
    tick();
    chk("lat_e2", 32'(valid), 0);
    tick();
    chk("lat_e3", 32'(valid), 1);
    tick();
    chk("pulse_width", 32'(valid), 0);

    // Narrow counter: one period of 5, then silence until saturation.
    en4 = 1'b1;
    repeat (2) tick();
    sig4 = 1'b1;
    tick();
    sig4 = 1'b0;
    repeat (4) tick();
    sig4 = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 1) sig4 = 1'b0;
      if (i == 3) begin
        chk("t3_valid", 32'(valid4), 1);
        chk("t3_period", 32'(period4), 5);
      end
      if (i >= 17) chk("t3_timeout", 32'(timeout4), (i == 18) ? 1 : 0);
      if (i == 18) chk("t3_excl", 32'(valid4), 0);
    end
    chk("t3_period_hold", 32'(period4), 5);
    chk("t3_state_arm", 32'(u_dut4.state_q), 32'(ST_ARM));

    // Narrow counter: second rise lands exactly on the saturating count.
    en4 = 1'b0;
    tick();
    en4 = 1'b1;
    repeat (2) tick();
    tmo = 0;
    sig4 = 1'b1;
    tick();
    sig4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (timeout4) tmo++;
    end
    sig4 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) sig4 = 1'b0;
      if (timeout4) tmo++;
      if (i == 3) begin
        chk("t4_valid", 32'(valid4), 1);
        chk("t4_period", 32'(period4), 15);
      end
    end
    chk("t4_no_timeout", 32'(tmo), 0);

    // Enable dropped mid-period: next report needs two fresh rises.
    exp_period = 16'd8;
    exp_high   = DUTY ? 16'd4 : 16'd0;
    restart();
    v0 = valid_cnt;
    wave(8, 4, 3);
    chk("t5_before", 32'(valid_cnt - v0), 2);
    for (int i = 0; i < 8; i++) begin
      sig = (i < 4);
      en  = !(i == 5 || i == 6);
      tick();
    end
    sig = 1'b0;
    v1 = valid_cnt;
    chk("t5_drop", 32'(v1 - v0), 3);
    wave(8, 4, 1);
    chk("t5_first_rise", 32'(valid_cnt - v1), 0);
    wave(8, 4, 1);
    repeat (4) tick();
    chk("t5_second_rise", 32'(valid_cnt - v1), 1);

    // Asynchronous reset in the middle of a measurement.
    exp_period = 16'd6;
    exp_high   = DUTY ? 16'd2 : 16'd0;
    restart();
    wave(6, 2, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_period", 32'(period), 0);
    chk("t6_high", 32'(high), 0);
    chk("t6_valid", 32'(valid), 0);
    chk("t6_timeout", 32'(timeout), 0);
    chk("t6_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    repeat (2) tick();
    rst_n = 1'b1;
    v0 = valid_cnt;
    wave(6, 2, 4);
    repeat (4) tick();
    chk("t6_restart", 32'(valid_cnt - v0), 3);

    chk("main_timeouts", 32'(timeout_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
